serial_link_delay_line: RTL and testbench

Synthesizable, parametrised multi-channel delay line that delays each of `NumChannels` data lanes by a run-time-programmable number of clock cycles (0..`MaxDelay`). Each channel holds a fill/run state, and its output shows `DefaultValue` until its pipeline holds valid history. It sits in front of the serial link PHY/channel model to emulate per-lane skew and link latency in FPGA and emulation builds, where time-based (`#delay`) models cannot be used.

---
 rtl/serial_link_delay_pkg.sv | 16 +
 rtl/serial_link_delay_lane.sv | 118 +++++++++++
 rtl/serial_link_delay_line.sv | 70 +++++++
 tb/tb_serial_link_delay_line.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_delay_pkg.sv
// Shared types and helpers for the serial link delay line.
//   delay_state_e : per-lane fill/run state
//   ptr_w()       : width of a circular-buffer pointer for a given depth
package serial_link_delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } delay_state_e;

  // A depth-1 buffer still needs a 1-bit pointer.
  function automatic int ptr_w(input int max_delay);
    return (max_delay > 1) ? $clog2(max_delay) : 1;
  endfunction

endpackage

// File: rtl/serial_link_delay_lane.sv
// One lane of the delay line: circular history buffer, write pointer,
// fill/run FSM and delay clamp.
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | history not yet deep enough; outputs DefaultValue, valid 0
// RUN   | outputs {valid, data} read from the buffer d cycles back
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   cfg_delay_i   : requested delay, clamped to MaxDelay when latched
//   cfg_update_i  : strobe latching cfg_delay_i and restarting FILL
//   data_i/valid_i: lane input, written every cycle
//   data_o/valid_o: delayed output (bypass when d == 0)
//   run_o         : lane in RUN (only with SERIAL_LINK_DELAY_READY_EN)
module serial_link_delay_lane
  import serial_link_delay_pkg::*;
#(
  parameter int                   DataWidth    = 8,
  parameter int                   MaxDelay     = 16,
  parameter int                   InitDelay    = 0,
  parameter logic [DataWidth-1:0] DefaultValue = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [$clog2(MaxDelay+1)-1:0]  cfg_delay_i,
  input  logic                           cfg_update_i,
  input  logic [DataWidth-1:0]           data_i,
  input  logic                           valid_i,
  output logic [DataWidth-1:0]           data_o,
  output logic                           valid_o
`ifdef SERIAL_LINK_DELAY_READY_EN
  ,
  output logic                           run_o
`endif
);

  localparam int DW = $clog2(MaxDelay + 1);
  localparam int PW = ptr_w(MaxDelay);
  localparam logic [DW-1:0]   MaxD = DW'(MaxDelay);
  localparam logic [PW+1:0]   MaxW = (PW+2)'(MaxDelay);

  delay_state_e         state_q, eff_state;
  logic [DW-1:0]        d_q, fcnt_q, eff_d, eff_fcnt, cfg_clamped;
  logic [PW-1:0]        wr_ptr_q, rd_idx;
  logic [PW+1:0]        rd_sum;
  logic [DataWidth-1:0] mem_data [MaxDelay];
  logic [MaxDelay-1:0]  mem_valid;
  logic                 upd;

  assign upd         = cfg_update_i & ~rst_i;
  assign cfg_clamped = (cfg_delay_i > MaxD) ? MaxD : cfg_delay_i;

  // An update takes effect in its own cycle: that cycle already counts as
  // the first FILL cycle (fcnt = 0), so FILL lasts exactly d cycles and the
  // first RUN cycle shows the sample written alongside the update.
  always_comb begin
    eff_d     = d_q;
    eff_state = state_q;
    eff_fcnt  = fcnt_q;
    if (upd) begin
      eff_d     = cfg_clamped;
      eff_state = FILL;
      eff_fcnt  = '0;
    end
    if (eff_d == '0) eff_state = RUN;
  end

  // (wr_ptr - d) mod MaxDelay without a negative intermediate; d == MaxDelay
  // lands on wr_ptr, i.e. the oldest entry, read before it is overwritten.
  always_comb begin
    rd_sum = (PW+2)'(wr_ptr_q) + MaxW - (PW+2)'(eff_d);
    rd_idx = (rd_sum >= MaxW) ? PW'(rd_sum - MaxW) : PW'(rd_sum);
  end

  always_comb begin
    data_o  = DefaultValue;
    valid_o = 1'b0;
    if (eff_d == '0) begin
      data_o  = data_i;
      valid_o = valid_i;
    end else if (eff_state == RUN) begin
      data_o  = mem_data[rd_idx];
      valid_o = mem_valid[rd_idx];
    end
  end

`ifdef SERIAL_LINK_DELAY_READY_EN
  assign run_o = (eff_state == RUN);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FILL;
      d_q       <= DW'(InitDelay);
      fcnt_q    <= '0;
      wr_ptr_q  <= '0;
      mem_valid <= '0;
    end else begin
      mem_valid[wr_ptr_q] <= valid_i;
      wr_ptr_q <= (wr_ptr_q == PW'(MaxDelay - 1)) ? '0 : wr_ptr_q + 1'b1;
      d_q      <= eff_d;
      if (eff_state == FILL) begin
        fcnt_q  <= eff_fcnt + 1'b1;
        state_q <= (eff_fcnt == eff_d - 1'b1) ? RUN : FILL;
      end else begin
        fcnt_q  <= eff_fcnt;
        state_q <= RUN;
      end
    end
  end

  // Payload storage carries no reset; the stored valid bits guard it.
  always_ff @(posedge clk_i) begin
    mem_data[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_link_delay_line.sv
// Multi-channel programmable delay line emulating per-lane skew and link
// latency in front of the serial link PHY model.
//
// Optional feature macro: SERIAL_LINK_DELAY_READY_EN adds registered
// ready_o, high the cycle after every lane is in RUN.
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   cfg_delay_i   : per-lane requested delay (0..MaxDelay, larger clamps)
//   cfg_update_i  : per-lane strobe latching cfg_delay_i
//   data_i/valid_i: per-lane input stream, one sample per cycle
//   data_o/valid_o: per-lane delayed stream, DefaultValue while filling
//   ready_o       : all lanes running (macro builds only)
module serial_link_delay_line
  import serial_link_delay_pkg::*;
#(
  parameter int                   NumChannels  = 4,
  parameter int                   DataWidth    = 8,
  parameter int                   MaxDelay     = 16,
  parameter int                   InitDelay    = 0,
  parameter logic [DataWidth-1:0] DefaultValue = '0
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [NumChannels-1:0][$clog2(MaxDelay+1)-1:0]  cfg_delay_i,
  input  logic [NumChannels-1:0]                          cfg_update_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]           data_i,
  input  logic [NumChannels-1:0]                          valid_i,
  output logic [NumChannels-1:0][DataWidth-1:0]           data_o,
  output logic [NumChannels-1:0]                          valid_o
`ifdef SERIAL_LINK_DELAY_READY_EN
  ,
  output logic                                            ready_o
`endif
);

`ifdef SERIAL_LINK_DELAY_READY_EN
  logic [NumChannels-1:0] lane_run;
`endif

  for (genvar c = 0; c < NumChannels; c++) begin : g_lane
    serial_link_delay_lane #(
      .DataWidth   (DataWidth),
      .MaxDelay    (MaxDelay),
      .InitDelay   (InitDelay),
      .DefaultValue(DefaultValue)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_delay_i (cfg_delay_i[c]),
      .cfg_update_i(cfg_update_i[c]),
      .data_i      (data_i[c]),
      .valid_i     (valid_i[c]),
      .data_o      (data_o[c]),
      .valid_o     (valid_o[c])
`ifdef SERIAL_LINK_DELAY_READY_EN
      ,
      .run_o       (lane_run[c])
`endif
    );
  end

`ifdef SERIAL_LINK_DELAY_READY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) ready_o <= 1'b0;
    else       ready_o <= &lane_run;
  end
`endif

endmodule

// File: tb/tb_serial_link_delay_line.sv
module tb_serial_link_delay_line;
  import serial_link_delay_pkg::*;

  localparam logic [7:0] DEF = 8'hEE;

  logic            clk;
  logic            rst;
  logic [3:0][4:0] cfg_delay;
  logic [3:0]      cfg_update;
  logic [3:0][7:0] data_in;
  logic [3:0]      valid_in;
  logic [3:0][7:0] data_out;
  logic [3:0]      valid_out;
`ifdef SERIAL_LINK_DELAY_READY_EN
  logic            ready;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] hist_d [4][256];
  logic       hist_v [4][256];

  typedef struct {
    logic [7:0] din;
    logic       exp_v;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vecs [8];

  serial_link_delay_line #(
    .NumChannels (4),
    .DataWidth   (8),
    .MaxDelay    (16),
    .InitDelay   (3),
    .DefaultValue(DEF)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_delay_i (cfg_delay),
    .cfg_update_i(cfg_update),
    .data_i      (data_in),
    .valid_i     (valid_in),
    .data_o      (data_out),
    .valid_o     (valid_out)
`ifdef SERIAL_LINK_DELAY_READY_EN
    ,
    .ready_o     (ready)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
    $fatal(1, "time limit");
  end

  function automatic logic [3:0][4:0] mk_cfg(input int d0, input int d1, input int d2, input int d3);
    logic [3:0][4:0] r;
    r[0] = 5'(d0);
    r[1] = 5'(d1);
    r[2] = 5'(d2);
    r[3] = 5'(d3);
    return r;
  endfunction

  task automatic drive(input logic [3:0] upd, input logic [3:0][4:0] cfg, input logic [3:0] vld);
    cfg_update = upd;
    cfg_delay  = cfg;
    valid_in   = vld;
    for (int c = 0; c < 4; c++) begin
      data_in[c]     = 8'(cyc + c * 64);
      hist_d[c][cyc] = data_in[c];
      hist_v[c][cyc] = vld[c];
    end
  endtask

  task automatic set_lane(input int c, input logic [7:0] d, input logic v);
    data_in[c]     = d;
    valid_in[c]    = v;
    hist_d[c][cyc] = d;
    hist_v[c][cyc] = v;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int c, input logic exp_v,
                       input logic [7:0] exp_d, input logic chk_d);
    total++;
    if (valid_out[c] !== exp_v || (chk_d && data_out[c] !== exp_d)) begin
      bad++;
      $display("FAIL %s lane=%0d cyc=%0d got valid=%b data=%h expected valid=%b data=%h",
               name, c, cyc, valid_out[c], data_out[c], exp_v, exp_d);
    end
  endtask

  // Expected output of a running lane: whatever was driven d cycles ago.
  task automatic expect_hist(input string name, input int c, input int d);
    check(name, c, hist_v[c][cyc-d], hist_d[c][cyc-d], hist_v[c][cyc-d]);
  endtask

  task automatic expect_fill(input string name, input int c);
    check(name, c, 1'b0, DEF, 1'b1);
  endtask

`ifdef SERIAL_LINK_DELAY_READY_EN
  task automatic check_ready(input string name, input logic exp);
    total++;
    if (ready !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got ready=%b expected ready=%b", name, cyc, ready, exp);
    end
  endtask
`endif

  initial begin
    // Reset, InitDelay=3: lane 0 gets 0x11, 0x22, ... from cycle 0.
    vecs[0] = '{8'h11, 1'b0, DEF};
    vecs[1] = '{8'h22, 1'b0, DEF};
    vecs[2] = '{8'h33, 1'b0, DEF};
    vecs[3] = '{8'h44, 1'b1, 8'h11};
    vecs[4] = '{8'h55, 1'b1, 8'h22};
    vecs[5] = '{8'h66, 1'b1, 8'h33};
    vecs[6] = '{8'h77, 1'b1, 8'h44};
    vecs[7] = '{8'h88, 1'b1, 8'h55};

    rst = 1'b1;
    drive(4'h0, mk_cfg(0, 0, 0, 0), 4'h0);
    next_cycle();
    next_cycle();
    drive(4'h0, mk_cfg(0, 0, 0, 0), 4'hF);
    #1;
    for (int c = 0; c < 4; c++) expect_fill("reset_out", c);
`ifdef SERIAL_LINK_DELAY_READY_EN
    check_ready("reset_ready", 1'b0);
`endif
    next_cycle();
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      drive(4'h0, mk_cfg(0, 0, 0, 0), 4'hF);
      set_lane(0, vecs[k].din, 1'b1);
      #1;
      check("init_delay_vec", 0, vecs[k].exp_v, vecs[k].exp_d, 1'b1);
      if (k < 3) expect_fill("init_fill_lane3", 3);
      else       expect_hist("init_run_lane3", 3, 3);
      next_cycle();
    end

    // Lane 1 -> d=5, later lane 0 -> d=0 (bypass); lane 1 must not glitch.
    for (int k = 0; k < 12; k++) begin
      drive((k == 0) ? 4'b0010 : ((k == 7) ? 4'b0001 : 4'b0000), mk_cfg(0, 5, 0, 0), 4'hF);
      #1;
      if (k < 7) expect_hist("s2_lane0_d3", 0, 3);
      else       expect_hist("s2_lane0_bypass", 0, 0);
      if (k < 5) expect_fill("s2_lane1_fill", 1);
      else       expect_hist("s2_lane1_d5", 1, 5);
      next_cycle();
    end

    // Lane 3 -> d=16, lane 2 requests 31 (clamps to 16); 40 valid samples.
    for (int k = 0; k < 60; k++) begin
      drive((k == 0) ? 4'b1100 : 4'b0000, mk_cfg(0, 5, 31, 16),
            (k < 40) ? 4'hF : 4'b0011);
      #1;
      if (k < 16) begin
        expect_fill("s3_max_fill", 3);
        expect_fill("s3_clamp_fill", 2);
      end else begin
        expect_hist("s3_max_run", 3, 16);
        expect_hist("s3_clamp_run", 2, 16);
      end
      next_cycle();
    end

    // Lane 2: d=4, then mid-stream d=2 with 0xA5 in the update cycle.
    for (int k = 0; k < 12; k++) begin
      drive((k == 0 || k == 8) ? 4'b0100 : 4'b0000,
            mk_cfg(0, 5, (k == 8) ? 2 : 4, 16), 4'hF);
      if (k == 8) set_lane(2, 8'hA5, 1'b1);
      #1;
      if (k < 4)        expect_fill("s4_d4_fill", 2);
      else if (k < 8)   expect_hist("s4_d4_run", 2, 4);
      else if (k < 10)  expect_fill("s4_d2_fill", 2);
      else if (k == 10) check("s4_a5", 2, 1'b1, 8'hA5, 1'b1);
      else              expect_hist("s4_d2_run", 2, 2);
      next_cycle();
    end

    // All lanes d=6, then reset mid-stream.
    for (int k = 0; k < 10; k++) begin
      drive((k == 0) ? 4'hF : 4'h0, mk_cfg(6, 6, 6, 6), 4'hF);
      #1;
      if (k >= 6) begin
        expect_hist("s5_pre_lane0", 0, 6);
        expect_hist("s5_pre_lane3", 3, 6);
      end
`ifdef SERIAL_LINK_DELAY_READY_EN
      if (k >= 1) check_ready("s5_pre_ready", (k >= 7) ? 1'b1 : 1'b0);
`endif
      next_cycle();
    end

    rst = 1'b1;
    drive(4'h0, mk_cfg(6, 6, 6, 6), 4'hF);
    next_cycle();
    drive(4'h0, mk_cfg(6, 6, 6, 6), 4'hF);
    #1;
    for (int c = 0; c < 4; c++) expect_fill("s5_reset_out", c);
`ifdef SERIAL_LINK_DELAY_READY_EN
    check_ready("s5_reset_ready", 1'b0);
`endif
    next_cycle();
    rst = 1'b0;

    // Lanes 0-2 back to d=6 in the first cycle after reset; lane 3 keeps 3.
    for (int p = 0; p < 9; p++) begin
      drive((p == 0) ? 4'b0111 : 4'b0000, mk_cfg(6, 6, 6, 0), 4'hF);
      #1;
      if (p < 6) expect_fill("s5_post_lane0_fill", 0);
      else       expect_hist("s5_post_lane0_run", 0, 6);
      if (p < 3) expect_fill("s5_post_lane3_fill", 3);
      else       expect_hist("s5_post_lane3_run", 3, 3);
`ifdef SERIAL_LINK_DELAY_READY_EN
      check_ready("s5_post_ready", (p >= 7) ? 1'b1 : 1'b0);
`endif
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
